mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 The block SHALL have these ports: clk  in  1  rising-edge clock; rstn  in  1  reset, asynchronous, active-low.
REQ-002 The block SHALL take these EX/MEM inputs: EXMEM_RegWrite, EXMEM_MemToReg, EXMEM_MemRead, EXMEM_MemWrite  in  1 each  control bits; EXMEM_instr, EXMEM_npc, EXMEM_reg_2, EXMEM_ALU_result  in  32 each; EXMEM_rd  in  5.
REQ-003 The block SHALL have these data-memory ports: dm_req  out  1; dm_we  out  1; dm_addr  out  32; dm_wdata  out  32; dm_wstrb  out  4; dm_rdata  in  32; dm_ack  in  1 (one-cycle pulse, read data valid with it).
REQ-004 The block SHALL have these outputs: mem_stall  out  1, which freezes PC/IFID/IDEX/EXMEM; MEMWB_RegWrite, MEMWB_MemToReg, MEMWB_misalign  out  1 each; MEMWB_rd  out  5; MEMWB_ALU_result, MEMWB_mem_data, MEMWB_npc, MEMWB_instr  out  32 each.

Function
REQ-005 The FSM SHALL have two states: IDLE and WAIT.
REQ-006 A memop SHALL be defined as (EXMEM_MemRead | EXMEM_MemWrite) that is aligned; size comes from funct3 = EXMEM_instr[14:12].
REQ-007 Transitions: IDLE→WAIT on memop; WAIT→IDLE on dm_ack; otherwise the state SHALL hold.
REQ-008 In WAIT, dm_req SHALL be 1; dm_addr/dm_we/dm_wdata/dm_wstrb SHALL be registered at IDLE→WAIT and held stable until ack; all four SHALL be 0 in IDLE.
REQ-009 mem_stall SHALL equal (IDLE & memop) | (WAIT & !dm_ack), combinationally.
REQ-010 MEMWB registers SHALL load on every edge where mem_stall=0; when mem_stall=1 they SHALL load a bubble (all control bits 0, other fields unchanged).
REQ-011 Latency: a non-memory instruction SHALL take 1 cycle EXMEM→MEMWB; a memop SHALL take 1+k cycles, where k is the WAIT cycles up to and including ack (minimum 2).
REQ-012 Store strobes: SB → one-hot at addr[1:0], wdata = byte×4; SH → 0011/1100 by addr[1], wdata = half×2; SW → 1111.
REQ-013 Load extraction SHALL use the latched addr[1:0]: LB/LH sign-extend; LBU/LHU zero-extend; LW passes through. MEMWB_mem_data SHALL capture the extracted dm_rdata at the ack edge.
REQ-014 funct3 values 011/110/111 SHALL be treated as word.
REQ-015 Misaligned access (half with addr[0]=1; word with addr[1:0]≠0) SHALL issue no request and no stall, and SHALL pass through in 1 cycle with MEMWB_misalign=1 and MEMWB_RegWrite=0.
REQ-016 dm_ack in IDLE SHALL be ignored.
REQ-017 EXMEM inputs change while in WAIT SHALL not affect the latched request.
REQ-018 Simultaneous ack and a new memop in EXMEM: impossible by design, since EXMEM is frozen until the ack cycle; the next memop SHALL be seen in IDLE the following cycle.

Reset
REQ-019 Asserting rstn low SHALL immediately force IDLE, dm_req=0, mem_stall=0, and all MEMWB outputs and latched request registers to 0, including mid-WAIT; a late dm_ack after reset SHALL be ignored.
REQ-020 The first edge after deassertion SHALL behave as IDLE.

Structure
REQ-021 The shared package SHALL hold the FSM state encoding and the funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
REQ-022 There SHALL be one combinational sub-module, load_align (rdata, addr[1:0], funct3 → 32-bit result); strobe generation and the FSM stay in the top module.

Verification
REQ-023 The bench SHALL check: ADD (RegWrite=1, ALU_result=0x1234, rd=5) → MEMWB on the next edge with RegWrite=1, rd=5, mem_stall never 1.
REQ-024 The bench SHALL check: LB at addr 0x103, ack after 3 WAIT cycles, rdata 0x80FFFFFF → mem_stall high 3 cycles, one bubble per stalled edge, MEMWB_mem_data 0xFFFFFF80.
REQ-025 The bench SHALL check: SH at addr 0x202, reg_2 0xABCD5678, ack immediately → dm_wstrb 1100, dm_wdata 0x56785678, dm_we=1, dm_req high exactly 1 cycle.
REQ-026 The bench SHALL check: LW at addr 0x101 → no dm_req, MEMWB_misalign=1, MEMWB_RegWrite=0, 1-cycle latency.
REQ-027 The bench SHALL check: rstn pulsed low in the 2nd WAIT cycle, ack arriving after release → all outputs 0 at once, state IDLE, ack ignored, MEMWB stays 0.
REQ-028 The bench SHALL check: back-to-back LW 0x10 then SW 0x14, each acked in 1 cycle → each access a distinct req, no duplicate writeback.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_access_stage_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = XLEN / 8;
  localparam int unsigned REG_AW = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  // Request payload latched on entry to WAIT and held until ack.
  typedef struct packed {
    logic              we;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [STRB_W-1:0] wstrb;
  } dm_req_t;

  // Access size from funct3; every unlisted encoding (011/110/111) is a word.
  function automatic size_t f3_size(input logic [2:0] f3);
    size_t sz;
    case (f3)
      F3_LB, F3_LBU: sz = SZ_BYTE;
      F3_LH, F3_LHU: sz = SZ_HALF;
      F3_LW:         sz = SZ_WORD;
      default:       sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Extracts and extends the addressed byte/half/word from a memory read word.
module load_align
  import mem_access_stage_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result_c
);

  logic [XLEN-1:0] shifted;
  logic            is_unsigned;

  // Shift the addressed lane down, then sign- or zero-extend by size.
  always_comb begin
    shifted     = rdata >> {addr, 3'b000};
    is_unsigned = (funct3 == F3_LBU) || (funct3 == F3_LHU);
    result_c    = rdata;
    case (f3_size(funct3))
      SZ_BYTE: result_c = is_unsigned ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: result_c = is_unsigned ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
      default: result_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory requests, stalls until ack, fills MEM/WB.
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              EXMEM_RegWrite,
  input  logic              EXMEM_MemToReg,
  input  logic              EXMEM_MemRead,
  input  logic              EXMEM_MemWrite,
  input  logic [XLEN-1:0]   EXMEM_instr,
  input  logic [XLEN-1:0]   EXMEM_npc,
  input  logic [XLEN-1:0]   EXMEM_reg_2,
  input  logic [XLEN-1:0]   EXMEM_ALU_result,
  input  logic [REG_AW-1:0] EXMEM_rd,
  output logic              dm_req,
  output logic              dm_we,
  output logic [XLEN-1:0]   dm_addr,
  output logic [XLEN-1:0]   dm_wdata,
  output logic [STRB_W-1:0] dm_wstrb,
  input  logic [XLEN-1:0]   dm_rdata,
  input  logic              dm_ack,
  output logic              mem_stall,
  output logic              MEMWB_RegWrite,
  output logic              MEMWB_MemToReg,
  output logic              MEMWB_misalign,
  output logic [REG_AW-1:0] MEMWB_rd,
  output logic [XLEN-1:0]   MEMWB_ALU_result,
  output logic [XLEN-1:0]   MEMWB_mem_data,
  output logic [XLEN-1:0]   MEMWB_npc,
  output logic [XLEN-1:0]   MEMWB_instr
);

  state_t            state;
  dm_req_t           req_q;
  size_t             size_c;
  logic [1:0]        off_c;
  logic              access_c;
  logic              aligned_c;
  logic              memop_c;
  logic              misalign_c;
  logic [STRB_W-1:0] wstrb_c;
  logic [XLEN-1:0]   wdata_c;
  logic [XLEN-1:0]   load_data_c;

  // Classify the EX/MEM access and build store strobes/data.
  always_comb begin
    off_c      = EXMEM_ALU_result[1:0];
    size_c     = f3_size(EXMEM_instr[14:12]);
    access_c   = EXMEM_MemRead | EXMEM_MemWrite;
    aligned_c  = 1'b0;
    wstrb_c    = '0;
    wdata_c    = '0;
    case (size_c)
      SZ_BYTE: aligned_c = 1'b1;
      SZ_HALF: aligned_c = ~off_c[0];
      default: aligned_c = (off_c == 2'b00);
    endcase
    memop_c    = access_c & aligned_c;
    misalign_c = access_c & ~aligned_c;
    if (EXMEM_MemWrite) begin
      case (size_c)
        SZ_BYTE: begin
          wstrb_c = STRB_W'(1) << off_c;
          wdata_c = {4{EXMEM_reg_2[7:0]}};
        end
        SZ_HALF: begin
          wstrb_c = off_c[1] ? 4'b1100 : 4'b0011;
          wdata_c = {2{EXMEM_reg_2[15:0]}};
        end
        default: begin
          wstrb_c = '1;
          wdata_c = EXMEM_reg_2;
        end
      endcase
    end
  end

  // Stall while a request is pending; forced low while reset is asserted.
  always_comb begin
    mem_stall = rstn & (((state == ST_IDLE) & memop_c) |
                        ((state == ST_WAIT) & ~dm_ack));
  end

  assign dm_we    = req_q.we;
  assign dm_addr  = req_q.addr;
  assign dm_wdata = req_q.wdata;
  assign dm_wstrb = req_q.wstrb;

  load_align u_load_align (
    .rdata    (dm_rdata),
    .addr     (req_q.addr[1:0]),
    .funct3   (req_q.funct3),
    .result_c (load_data_c)
  );

  // Request FSM: latch the access on IDLE->WAIT, drop it on ack.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      dm_req <= 1'b0;
      req_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (memop_c) begin
            state  <= ST_WAIT;
            dm_req <= 1'b1;
            req_q  <= '{we:     EXMEM_MemWrite,
                        funct3: EXMEM_instr[14:12],
                        addr:   EXMEM_ALU_result,
                        wdata:  wdata_c,
                        wstrb:  wstrb_c};
          end
        end
        ST_WAIT: begin
          if (dm_ack) begin
            state  <= ST_IDLE;
            dm_req <= 1'b0;
            req_q  <= '0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          dm_req <= 1'b0;
          req_q  <= '0;
        end
      endcase
    end
  end

  // MEM/WB register: advance when not stalled, otherwise insert a bubble.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      MEMWB_RegWrite   <= 1'b0;
      MEMWB_MemToReg   <= 1'b0;
      MEMWB_misalign   <= 1'b0;
      MEMWB_rd         <= '0;
      MEMWB_ALU_result <= '0;
      MEMWB_mem_data   <= '0;
      MEMWB_npc        <= '0;
      MEMWB_instr      <= '0;
    end else if (mem_stall) begin
      MEMWB_RegWrite <= 1'b0;
      MEMWB_MemToReg <= 1'b0;
      MEMWB_misalign <= 1'b0;
    end else begin
      MEMWB_RegWrite   <= EXMEM_RegWrite & ~misalign_c;
      MEMWB_MemToReg   <= EXMEM_MemToReg;
      MEMWB_misalign   <= misalign_c;
      MEMWB_rd         <= EXMEM_rd;
      MEMWB_ALU_result <= EXMEM_ALU_result;
      MEMWB_mem_data   <= ((state == ST_WAIT) && !req_q.we) ? load_data_c : '0;
      MEMWB_npc        <= EXMEM_npc;
      MEMWB_instr      <= EXMEM_instr;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic        clk;
  logic        rstn;
  logic        EXMEM_RegWrite, EXMEM_MemToReg, EXMEM_MemRead, EXMEM_MemWrite;
  logic [31:0] EXMEM_instr, EXMEM_npc, EXMEM_reg_2, EXMEM_ALU_result;
  logic [4:0]  EXMEM_rd;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_stall;
  logic        MEMWB_RegWrite, MEMWB_MemToReg, MEMWB_misalign;
  logic [4:0]  MEMWB_rd;
  logic [31:0] MEMWB_ALU_result, MEMWB_mem_data, MEMWB_npc, MEMWB_instr;

  int errors = 0;
  int checks = 0;

  mem_access_stage dut (
    .clk(clk), .rstn(rstn),
    .EXMEM_RegWrite(EXMEM_RegWrite), .EXMEM_MemToReg(EXMEM_MemToReg),
    .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemWrite(EXMEM_MemWrite),
    .EXMEM_instr(EXMEM_instr), .EXMEM_npc(EXMEM_npc),
    .EXMEM_reg_2(EXMEM_reg_2), .EXMEM_ALU_result(EXMEM_ALU_result),
    .EXMEM_rd(EXMEM_rd),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_stall(mem_stall),
    .MEMWB_RegWrite(MEMWB_RegWrite), .MEMWB_MemToReg(MEMWB_MemToReg),
    .MEMWB_misalign(MEMWB_misalign), .MEMWB_rd(MEMWB_rd),
    .MEMWB_ALU_result(MEMWB_ALU_result), .MEMWB_mem_data(MEMWB_mem_data),
    .MEMWB_npc(MEMWB_npc), .MEMWB_instr(MEMWB_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [31:0] rdata;
    logic        exp_stall;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_mdata;
    logic        exp_mis;
    logic        exp_rw;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic mtr, input logic mr, input logic mw,
                       input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] reg2, input logic [4:0] rd);
    EXMEM_RegWrite   = rw;
    EXMEM_MemToReg   = mtr;
    EXMEM_MemRead    = mr;
    EXMEM_MemWrite   = mw;
    EXMEM_instr      = {17'd0, f3, 12'h003};
    EXMEM_npc        = 32'h0000_4000 + addr;
    EXMEM_reg_2      = reg2;
    EXMEM_ALU_result = addr;
    EXMEM_rd         = rd;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0);
  endtask

  int stall_cnt;
  int bubbles;
  int wb_cnt;

  initial begin
    //                rd wr f3      addr          reg2          rdata         st wstrb    wdata         mdata         mis rw
    vecs[0]  = '{1'b0,1'b0,3'b000,32'h0000_1234,32'h0,        32'h0,        1'b0,4'b0000,32'h0,        32'h0,        1'b0,1'b1};
    vecs[1]  = '{1'b1,1'b0,3'b010,32'h0000_0101,32'h0,        32'h0,        1'b0,4'b0000,32'h0,        32'h0,        1'b1,1'b0};
    vecs[2]  = '{1'b1,1'b0,3'b001,32'h0000_0203,32'h0,        32'h0,        1'b0,4'b0000,32'h0,        32'h0,        1'b1,1'b0};
    vecs[3]  = '{1'b0,1'b1,3'b010,32'h0000_0102,32'h0000_1111,32'h0,        1'b0,4'b0000,32'h0,        32'h0,        1'b1,1'b0};
    vecs[4]  = '{1'b0,1'b1,3'b000,32'h0000_0201,32'h1234_56EF,32'h0,        1'b1,4'b0010,32'hEFEF_EFEF,32'h0,        1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b1,3'b001,32'h0000_0202,32'hABCD_5678,32'h0,        1'b1,4'b1100,32'h5678_5678,32'h0,        1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b1,3'b010,32'h0000_0200,32'hCAFE_BABE,32'h0,        1'b1,4'b1111,32'hCAFE_BABE,32'h0,        1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b1,3'b111,32'h0000_0204,32'h1122_3344,32'h0,        1'b1,4'b1111,32'h1122_3344,32'h0,        1'b0,1'b0};
    vecs[8]  = '{1'b1,1'b0,3'b100,32'h0000_0102,32'h0,        32'h80FF_7F00,1'b1,4'b0000,32'h0,        32'h0000_00FF,1'b0,1'b1};
    vecs[9]  = '{1'b1,1'b0,3'b001,32'h0000_0202,32'h0,        32'h8001_1234,1'b1,4'b0000,32'h0,        32'hFFFF_8001,1'b0,1'b1};
    vecs[10] = '{1'b1,1'b0,3'b101,32'h0000_0200,32'h0,        32'h1234_F00D,1'b1,4'b0000,32'h0,        32'h0000_F00D,1'b0,1'b1};
    vecs[11] = '{1'b1,1'b0,3'b010,32'h0000_010C,32'h0,        32'hDEAD_BEEF,1'b1,4'b0000,32'h0,        32'hDEAD_BEEF,1'b0,1'b1};
    vecs[12] = '{1'b1,1'b0,3'b000,32'h0000_0100,32'h0,        32'h0000_007F,1'b1,4'b0000,32'h0,        32'h0000_007F,1'b0,1'b1};
    vecs[13] = '{1'b1,1'b0,3'b110,32'h0000_0108,32'h0,        32'h89AB_CDEF,1'b1,4'b0000,32'h0,        32'h89AB_CDEF,1'b0,1'b1};

    // Reset state
    rstn = 1'b0;
    dm_ack = 1'b0;
    dm_rdata = 32'h0;
    nop();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dm_req", 32'(dm_req), 32'h0);
    chk("rst_stall", 32'(mem_stall), 32'h0);
    chk("rst_dm_addr", dm_addr, 32'h0);
    chk("rst_wb_rw", 32'(MEMWB_RegWrite), 32'h0);
    chk("rst_wb_instr", MEMWB_instr, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // Table: single-cycle passes and one-cycle-ack memops
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(~vecs[i].wr_en, vecs[i].rd_en, vecs[i].rd_en, vecs[i].wr_en,
            vecs[i].f3, vecs[i].addr, vecs[i].reg2, 5'd5);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(mem_stall), 32'(vecs[i].exp_stall));
      chk($sformatf("v%0d_req_idle", i), 32'(dm_req), 32'h0);
      if (!vecs[i].exp_stall) begin
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_wb_rw", i), 32'(MEMWB_RegWrite), 32'(vecs[i].exp_rw));
        chk($sformatf("v%0d_wb_mis", i), 32'(MEMWB_misalign), 32'(vecs[i].exp_mis));
        chk($sformatf("v%0d_wb_rd", i), 32'(MEMWB_rd), 32'd5);
        chk($sformatf("v%0d_wb_alu", i), MEMWB_ALU_result, vecs[i].addr);
        chk($sformatf("v%0d_no_req", i), 32'(dm_req), 32'h0);
        nop();
      end else begin
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_req", i), 32'(dm_req), 32'h1);
        chk($sformatf("v%0d_we", i), 32'(dm_we), 32'(vecs[i].wr_en));
        chk($sformatf("v%0d_addr", i), dm_addr, vecs[i].addr);
        if (vecs[i].wr_en) begin
          chk($sformatf("v%0d_wstrb", i), 32'(dm_wstrb), 32'(vecs[i].exp_wstrb));
          chk($sformatf("v%0d_wdata", i), dm_wdata, vecs[i].exp_wdata);
        end
        chk($sformatf("v%0d_wait_stall", i), 32'(mem_stall), 32'h1);
        chk($sformatf("v%0d_bubble", i), 32'(MEMWB_RegWrite), 32'h0);
        dm_ack = 1'b1;
        dm_rdata = vecs[i].rdata;
        #1;
        chk($sformatf("v%0d_ack_stall", i), 32'(mem_stall), 32'h0);
        @(posedge clk);
        @(negedge clk);
        dm_ack = 1'b0;
        chk($sformatf("v%0d_req_drop", i), 32'(dm_req), 32'h0);
        chk($sformatf("v%0d_wb_rw", i), 32'(MEMWB_RegWrite), 32'(vecs[i].exp_rw));
        chk($sformatf("v%0d_wb_alu", i), MEMWB_ALU_result, vecs[i].addr);
        if (vecs[i].rd_en)
          chk($sformatf("v%0d_mdata", i), MEMWB_mem_data, vecs[i].exp_mdata);
        nop();
      end
    end

    // LB 0x103 acked in the third WAIT cycle
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd9);
    stall_cnt = 0;
    bubbles = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        dm_ack = 1'b1;
        dm_rdata = 32'h80FF_FFFF;
      end
      #1;
      if (mem_stall) stall_cnt++;
      if (c > 0) chk($sformatf("lb_addr_c%0d", c), dm_addr, 32'h0000_0103);
      @(posedge clk);
      @(negedge clk);
      if (c < 3 && !MEMWB_RegWrite) bubbles++;
    end
    dm_ack = 1'b0;
    nop();
    chk("lb_stall_cycles", 32'(stall_cnt), 32'd3);
    chk("lb_bubbles", 32'(bubbles), 32'd3);
    chk("lb_wb_rw", 32'(MEMWB_RegWrite), 32'h1);
    chk("lb_wb_rd", 32'(MEMWB_rd), 32'd9);
    chk("lb_mdata", MEMWB_mem_data, 32'hFFFF_FF80);

    // Reset pulsed in the second WAIT cycle of a store; late ack ignored
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'h1234_5678, 5'd3);
    @(posedge clk);
    @(negedge clk);
    chk("rw_req_before", 32'(dm_req), 32'h1);
    chk("rw_wdata_before", dm_wdata, 32'h1234_5678);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("rw_state", 32'(dut.state), 32'(ST_IDLE));
    chk("rw_req", 32'(dm_req), 32'h0);
    chk("rw_stall", 32'(mem_stall), 32'h0);
    chk("rw_addr", dm_addr, 32'h0);
    chk("rw_we", 32'(dm_we), 32'h0);
    chk("rw_wdata", dm_wdata, 32'h0);
    chk("rw_wstrb", 32'(dm_wstrb), 32'h0);
    chk("rw_wb_mdata", MEMWB_mem_data, 32'h0);
    chk("rw_wb_alu", MEMWB_ALU_result, 32'h0);
    chk("rw_wb_instr", MEMWB_instr, 32'h0);
    chk("rw_wb_npc", MEMWB_npc, 32'h0);
    chk("rw_wb_rd", 32'(MEMWB_rd), 32'h0);
    @(negedge clk);
    nop();
    rstn = 1'b1;
    dm_ack = 1'b1;
    dm_rdata = 32'hFFFF_FFFF;
    #1;
    chk("late_ack_stall", 32'(mem_stall), 32'h0);
    @(posedge clk);
    @(negedge clk);
    dm_ack = 1'b0;
    chk("late_ack_state", 32'(dut.state), 32'(ST_IDLE));
    chk("late_ack_req", 32'(dm_req), 32'h0);
    chk("late_ack_wb_rw", 32'(MEMWB_RegWrite), 32'h0);
    chk("late_ack_wb_mdata", MEMWB_mem_data, 32'h0);

    // Back-to-back LW 0x10 then SW 0x14, each acked in one cycle
    wb_cnt = 0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 5'd7);
    @(posedge clk);
    @(negedge clk);
    if (MEMWB_RegWrite) wb_cnt++;
    chk("bb_lw_req", 32'(dm_req), 32'h1);
    chk("bb_lw_addr", dm_addr, 32'h0000_0010);
    chk("bb_lw_we", 32'(dm_we), 32'h0);
    dm_ack = 1'b1;
    dm_rdata = 32'h5555_AAAA;
    @(posedge clk);
    @(negedge clk);
    if (MEMWB_RegWrite) wb_cnt++;
    dm_ack = 1'b0;
    chk("bb_gap_req", 32'(dm_req), 32'h0);
    chk("bb_lw_mdata", MEMWB_mem_data, 32'h5555_AAAA);
    chk("bb_lw_rd", 32'(MEMWB_rd), 32'd7);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 32'h0000_0014, 32'h0BAD_F00D, 5'd0);
    #1;
    chk("bb_sw_stall", 32'(mem_stall), 32'h1);
    @(posedge clk);
    @(negedge clk);
    if (MEMWB_RegWrite) wb_cnt++;
    chk("bb_sw_req", 32'(dm_req), 32'h1);
    chk("bb_sw_addr", dm_addr, 32'h0000_0014);
    chk("bb_sw_we", 32'(dm_we), 32'h1);
    chk("bb_sw_wdata", dm_wdata, 32'h0BAD_F00D);
    dm_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (MEMWB_RegWrite) wb_cnt++;
    dm_ack = 1'b0;
    nop();
    chk("bb_sw_drop", 32'(dm_req), 32'h0);
    chk("bb_sw_wb_alu", MEMWB_ALU_result, 32'h0000_0014);
    @(posedge clk);
    @(negedge clk);
    if (MEMWB_RegWrite) wb_cnt++;
    chk("bb_writebacks", 32'(wb_cnt), 32'd1);
    chk("bb_idle_req", 32'(dm_req), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
